// File: rtl/singlecycle_pkg.sv
// Shared register-file constants and types for the RV32I core family.
package singlecycle_pkg;

  localparam int NREGS_DEFAULT = 32;
  localparam int REGIDX_WIDTH  = $clog2(NREGS_DEFAULT);

  typedef logic [REGIDX_WIDTH-1:0] regidx_t;

  localparam regidx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy-bit scoreboard: one pending-producer flag per architectural register.
// Priority per bit is flush, then alloc, then clearing write, then hold.
module regfile_scoreboard
  import singlecycle_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int IDXW  = $clog2(NREGS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NRD-1:0][IDXW-1:0]  i_rs_addr,
  output logic [NRD-1:0]            o_rs_busy,
  input  logic [NWR-1:0]            i_wr_en,
  input  logic [NWR-1:0][IDXW-1:0]  i_wr_addr,
  input  logic [NWR-1:0]            i_wr_clr,
  input  logic                      i_alloc_en,
  input  logic [IDXW-1:0]           i_alloc_addr,
  input  logic                      i_flush
);

  logic [NREGS-1:0] busy;

  // x0 never has a producer
  assign busy[0] = 1'b0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
    logic busy_reg;
    logic busy_next;
    logic clr_hit;

    always_comb begin
      clr_hit = 1'b0;
      for (int w = 0; w < NWR; w++) begin
        if (i_wr_en[w] && i_wr_clr[w] && (i_wr_addr[w] == IDXW'(gi))) begin
          clr_hit = 1'b1;
        end
      end
    end

    // Alloc beats clear: the newly issued producer supersedes the retiring one
    always_comb begin
      busy_next = busy_reg;
      if (i_flush) begin
        busy_next = 1'b0;
      end else if (i_alloc_en && (i_alloc_addr == IDXW'(gi))) begin
        busy_next = 1'b1;
      end else if (clr_hit) begin
        busy_next = 1'b0;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        busy_reg <= 1'b0;
      end else begin
        busy_reg <= busy_next;
      end
    end

    assign busy[gi] = busy_reg;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_busy
    logic mask_hit;

    // A retiring write this cycle is forwarded, so the reader need not stall
    always_comb begin
      mask_hit = 1'b0;
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (i_wr_en[w] && i_wr_clr[w] && (i_wr_addr[w] == i_rs_addr[gi])) begin
            mask_hit = 1'b1;
          end
        end
      end
    end

    assign o_rs_busy[gi] = busy[i_rs_addr[gi]] & ~mask_hit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and
// an integrated RAW-hazard scoreboard. x0 reads as zero and is never busy.
module regfile_mp
  import singlecycle_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int IDXW  = $clog2(NREGS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NRD-1:0][IDXW-1:0]  i_rs_addr,
  output logic [NRD-1:0][XLEN-1:0]  o_rs_data,
  output logic [NRD-1:0]            o_rs_busy,
  input  logic [NWR-1:0]            i_wr_en,
  input  logic [NWR-1:0][IDXW-1:0]  i_wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  i_wr_data,
  input  logic [NWR-1:0]            i_wr_clr,
  input  logic                      i_alloc_en,
  input  logic [IDXW-1:0]           i_alloc_addr,
  input  logic                      i_flush
);

  logic [XLEN-1:0] stored [NREGS];

  // x0 has no storage; writes to it simply find no register to land in
  assign stored[0] = '0;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    logic [XLEN-1:0] data_reg;
    logic [XLEN-1:0] data_next;
    logic            wr_hit;

    // Later ports override earlier ones, so the highest index wins a collision
    always_comb begin
      wr_hit    = 1'b0;
      data_next = data_reg;
      for (int w = 0; w < NWR; w++) begin
        if (i_wr_en[w] && (i_wr_addr[w] == IDXW'(gi))) begin
          wr_hit    = 1'b1;
          data_next = i_wr_data[w];
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        data_reg <= '0;
      end else if (wr_hit) begin
        data_reg <= data_next;
      end
    end

    assign stored[gi] = data_reg;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [XLEN-1:0] rd_data;

    always_comb begin
      rd_data = stored[i_rs_addr[gi]];
      if ((BYPASS != 0) && (i_rs_addr[gi] != IDXW'(REG_ZERO))) begin
        for (int w = 0; w < NWR; w++) begin
          if (i_wr_en[w] && (i_wr_addr[w] == i_rs_addr[gi])) begin
            rd_data = i_wr_data[w];
          end
        end
      end
    end

    assign o_rs_data[gi] = rd_data;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rs_addr    (i_rs_addr),
    .o_rs_busy    (o_rs_busy),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_clr     (i_wr_clr),
    .i_alloc_en   (i_alloc_en),
    .i_alloc_addr (i_alloc_addr),
    .i_flush      (i_flush)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a dual-write bypassing instance and a
// single-write non-bypassing instance share the same stimulus.
module tb_regfile_mp;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0][4:0]      rs_addr;
  logic [1:0][31:0]     rs_data;
  logic [1:0]           rs_busy;
  logic [1:0][31:0]     rs_data_nb;
  logic [1:0]           rs_busy_nb;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_addr;
  logic [1:0][31:0]     wr_data;
  logic [1:0]           wr_clr;
  logic                 alloc_en;
  logic [4:0]           alloc_addr;
  logic                 flush;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (rs_data),
    .o_rs_busy    (rs_busy),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_wr_clr     (wr_clr),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .i_flush      (flush)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) dut_nb (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rs_addr    (rs_addr),
    .o_rs_data    (rs_data_nb),
    .o_rs_busy    (rs_busy_nb),
    .i_wr_en      (wr_en[0]),
    .i_wr_addr    (wr_addr[0]),
    .i_wr_data    (wr_data[0]),
    .i_wr_clr     (wr_clr[0]),
    .i_alloc_en   (alloc_en),
    .i_alloc_addr (alloc_addr),
    .i_flush      (flush)
  );

  typedef struct {
    string       name;
    int          dut_sel;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event chk_now;

  // Monitor: drains expectations at each falling edge or on demand
  initial begin
    exp_t        e;
    logic [31:0] act_data;
    logic        act_busy;
    forever begin
      @(negedge clk or chk_now);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut_sel == 0) begin
          act_data = rs_data[e.port];
          act_busy = rs_busy[e.port];
        end else begin
          act_data = rs_data_nb[e.port];
          act_busy = rs_busy_nb[e.port];
        end
        n_checks++;
        if (act_data !== e.data) begin
          n_fail++;
          $display("FAIL %s dut%0d p%0d data: got %h expected %h", e.name, e.dut_sel, e.port, act_data, e.data);
        end
        n_checks++;
        if (act_busy !== e.busy) begin
          n_fail++;
          $display("FAIL %s dut%0d p%0d busy: got %b expected %b", e.name, e.dut_sel, e.port, act_busy, e.busy);
        end
        $display("[%0t] %s dut%0d p%0d data=%h busy=%b", $time, e.name, e.dut_sel, e.port, act_data, act_busy);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string nm, input int d, input int p, input logic [31:0] data, input logic b);
    exp_t e;
    e.name    = nm;
    e.dut_sel = d;
    e.port    = p;
    e.data    = data;
    e.busy    = b;
    exp_q.push_back(e);
  endtask

  // Expected (data, busy) for the bypassing and then the non-bypassing instance
  task automatic expect_both(input string nm, input int p, input logic [31:0] d_bp, input logic b_bp,
                             input logic [31:0] d_nb, input logic b_nb);
    expect_rd(nm, 0, p, d_bp, b_bp);
    expect_rd(nm, 1, p, d_nb, b_nb);
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_clr   = '0;
    alloc_en = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    rs_addr    = '0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_addr = '0;
    idle();
    rs_addr[0] = 5'd1;
    rs_addr[1] = 5'd31;
    #2;
    expect_both("in_reset", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_both("in_reset", 1, 32'h0, 1'b0, 32'h0, 1'b0);

    cyc();
    rst_n = 1'b1;

    for (int a = 1; a < 32; a++) begin
      cyc();
      rs_addr[0] = 5'(a);
      rs_addr[1] = 5'(32 - a);
      expect_both("post_reset", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      expect_both("post_reset", 1, 32'h0, 1'b0, 32'h0, 1'b0);
    end

    // x0 write is dropped and never forwarded
    cyc();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd0; wr_data[0] = 32'hDEADBEEF;
    rs_addr[0] = 5'd0;
    expect_both("x0_write", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    idle();
    expect_both("x0_after", 0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Same-edge collision on x5: port 1 wins
    cyc();
    wr_en = 2'b11;
    wr_addr[0] = 5'd5; wr_data[0] = 32'h11111111;
    wr_addr[1] = 5'd5; wr_data[1] = 32'h22222222;
    rs_addr[0] = 5'd5;
    expect_both("x5_collide", 0, 32'h22222222, 1'b0, 32'h0, 1'b0);
    cyc();
    idle();
    expect_both("x5_stored", 0, 32'h22222222, 1'b0, 32'h11111111, 1'b0);

    // Bypass versus stored-only read of x7
    cyc();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'hA5A5A5A5;
    rs_addr[0] = 5'd7;
    expect_both("x7_bypass", 0, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    cyc();
    idle();
    expect_both("x7_stored", 0, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0);

    // Alloc x3, then retire it with a clearing write
    cyc();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    rs_addr[0] = 5'd3;
    expect_both("x3_alloc_same", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc();
    idle();
    expect_both("x3_busy", 0, 32'h0, 1'b1, 32'h0, 1'b1);
    cyc();
    wr_en[0] = 1'b1; wr_clr[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'h00000033;
    expect_both("x3_clr_write", 0, 32'h00000033, 1'b0, 32'h0, 1'b1);
    cyc();
    idle();
    expect_both("x3_cleared", 0, 32'h00000033, 1'b0, 32'h00000033, 1'b0);

    // Non-clearing write keeps x10 busy
    cyc();
    alloc_en = 1'b1; alloc_addr = 5'd10;
    cyc();
    idle();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd10; wr_data[0] = 32'h00000010;
    rs_addr[0] = 5'd10;
    expect_both("x10_noclr", 0, 32'h00000010, 1'b1, 32'h0, 1'b1);

    // Alloc and clear of x9 in one cycle leaves it busy
    cyc();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    wr_en[0] = 1'b1; wr_clr[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'h00000099;
    rs_addr[0] = 5'd9;
    rs_addr[1] = 5'd10;
    expect_both("x9_alloc_clr", 0, 32'h00000099, 1'b0, 32'h0, 1'b0);
    expect_both("x10_hold", 1, 32'h00000010, 1'b1, 32'h00000010, 1'b1);
    cyc();
    idle();
    expect_both("x9_still_busy", 0, 32'h00000099, 1'b1, 32'h00000099, 1'b1);

    // Flush outranks a concurrent alloc and leaves data untouched
    cyc();
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9;
    expect_both("x9_flush_same", 0, 32'h00000099, 1'b1, 32'h00000099, 1'b1);
    expect_both("x10_flush_same", 1, 32'h00000010, 1'b1, 32'h00000010, 1'b1);
    cyc();
    idle();
    expect_both("x9_flushed", 0, 32'h00000099, 1'b0, 32'h00000099, 1'b0);
    expect_both("x10_flushed", 1, 32'h00000010, 1'b0, 32'h00000010, 1'b0);

    // Asynchronous reset mid-cycle clears x4 data and busy before the next edge
    cyc();
    wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h00001234;
    alloc_en = 1'b1; alloc_addr = 5'd4;
    rs_addr[0] = 5'd1;
    cyc();
    idle();
    rs_addr[0] = 5'd4;
    expect_both("x4_pre_reset", 0, 32'h00001234, 1'b1, 32'h00001234, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_both("x4_async_rst", 0, 32'h0, 1'b0, 32'h0, 1'b0);
    -> chk_now;
    #1;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 32'h00005555;
    alloc_en = 1'b1; alloc_addr = 5'd4;
    cyc();
    idle();
    rst_n = 1'b1;
    expect_both("x4_rst_discard", 0, 32'h0, 1'b0, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
